// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and uart_tx-side signals of the
// shared-UART arbiter. The optional lock vector exists only when
// UART_TX_ARB_LOCK_EN is defined.
//   slave  : arbiter view
//   master : client / environment view
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           timeout;
  logic           uart_send;
  logic [7:0]     uart_data;
  logic           uart_busy;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0]   lock;

  modport slave  (input  req, req_data, uart_busy, lock,
                  output ack, grant, timeout, uart_send, uart_data);
  modport master (output req, req_data, uart_busy, lock,
                  input  ack, grant, timeout, uart_send, uart_data);
`else
  modport slave  (input  req, req_data, uart_busy,
                  output ack, grant, timeout, uart_send, uart_data);
  modport master (output req, req_data, uart_busy,
                  input  ack, grant, timeout, uart_send, uart_data);
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N requesters.
// Round-robin pick in IDLE, latch the winner's byte, pulse uart_send once,
// wait for uart_busy to rise (ack) or for BUSY_TIMEOUT cycles (timeout),
// then wait for uart_busy to fall before returning to IDLE.
// Optional feature macro: UART_TX_ARB_LOCK_EN (adds lock[N-1:0] so the
// previous winner can keep the UART for multi-byte messages).
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int             PW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]   ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]  PTR_INIT = PW'(N - 1);
  localparam logic [7:0]     TO_LAST  = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [7:0]    data_q, data_d;
  logic          send_q, send_d;
  logic          timeout_q, timeout_d;
`ifdef UART_TX_ARB_LOCK_EN
  // Set when the last transfer completed normally; a timeout cancels the lock.
  logic          lock_ok_q, lock_ok_d;
`endif

  logic          found_s;
  logic [PW-1:0] win_s;
  logic [PW-1:0] idx_s;
  int            idx_i;

  // Winner selection: first request after ptr, wrapping; lock overrides.
  always_comb begin
    found_s = 1'b0;
    win_s   = ptr_q;
    idx_s   = ptr_q;
    idx_i   = 0;
    for (int o = 1; o <= N; o++) begin
      idx_i = int'(ptr_q) + o;
      idx_i = (idx_i >= N) ? (idx_i - N) : idx_i;
      idx_s = PW'(idx_i);
      if (!found_s && bus.req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    if (lock_ok_q && bus.lock[ptr_q] && bus.req[ptr_q]) begin
      found_s = 1'b1;
      win_s   = ptr_q;
    end else begin
      win_s   = win_s;
    end
`endif
  end

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    data_d    = data_q;
    ack_d     = '0;
    send_d    = 1'b0;
    timeout_d = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_ok_d = lock_ok_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found_s && !bus.uart_busy) begin
          state_d = S_SEND;
          ptr_d   = win_s;
          grant_d = ONE_HOT0 << win_s;
          data_d  = bus.req_data[{win_s, 3'b000} +: 8];
          send_d  = 1'b1;
        end else begin
          grant_d = '0;
        end
      end
      S_SEND: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = 8'd0;
      end
      S_WAIT_BUSY: begin
        if (bus.uart_busy) begin
          ack_d   = ONE_HOT0 << ptr_q;
          state_d = S_WAIT_DONE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_ok_d = 1'b1;
`endif
        end else if (cnt_q == TO_LAST) begin
          // uart_tx never responded: give up, keep ptr so others go first.
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = S_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_ok_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.uart_busy) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears all outputs at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_INIT;
      cnt_q     <= 8'd0;
      grant_q   <= '0;
      ack_q     <= '0;
      data_q    <= 8'd0;
      send_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_ok_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      send_q    <= send_d;
      timeout_q <= timeout_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_ok_q <= lock_ok_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.grant     = grant_q;
  assign bus.timeout   = timeout_q;
  assign bus.uart_send = send_q;
  assign bus.uart_data = data_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between N requesters.
- Arbitrates round-robin, latches the winner's byte, and drives the uart_tx send/data inputs.
- Sequences each transfer from uart_tx busy: one send pulse, wait for busy to rise, wait for busy to fall.
- Sits between client blocks (debug printers, command responders) and the single UART pin driver.

Parameters:
- N, 4, number of requesters (2..16).
- BUSY_TIMEOUT, 15, max cycles in WAIT_BUSY before the transfer is abandoned (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  per-requester byte request; level, held until ack.
- req_data  in  8*N  byte for requester i at bits [8i+7:8i]; stable while req[i]=1.
- ack  out  N  one-cycle pulse: requester's byte accepted by uart_tx.
- grant  out  N  one-hot current owner; 0 when idle.
- timeout  out  1  one-cycle pulse: uart_busy never rose within BUSY_TIMEOUT.
- uart_send  out  1  to uart_tx send; one-cycle pulse.
- uart_data  out  8  to uart_tx data; held from the grant until the next grant.
- uart_busy  in  1  from uart_tx busy.
- lock  in  N  only present with UART_TX_ARB_LOCK_EN.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) drives every output to 0 immediately:
  - state=IDLE, ptr=N-1, so requester 0 wins first; timeout counter=0.
  - Reset mid-transfer aborts silently, with no ack; uart_tx is reset by its own reset.
- IDLE:
  - If |req and !uart_busy at edge k: winner = first set req[i] scanning i = ptr+1 .. ptr+N mod N.
  - At that edge: grant=onehot(winner), uart_data=req_data[winner], ptr=winner, go SEND.
  - If uart_busy=1, stay in IDLE; no grant is issued.
- SEND: uart_send=1 for exactly this one cycle; go WAIT_BUSY; counter cleared.
- WAIT_BUSY:
  - uart_busy=1: ack[winner] pulses the next cycle; go WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT: timeout pulses, no ack, grant=0, go IDLE. ptr stays at the winner, so others get priority on the retry.
- WAIT_DONE: on uart_busy=0, set grant=0 and go IDLE.
  - A new grant is possible on the following edge, so there is a minimum 1-cycle gap between busy falling and the next uart_send.
- Latency: req at edge k gives uart_send high in cycle k+1. ack follows 1 cycle after busy is first sampled high.
- Requester rules:
  - Must not change req_data[i] while req[i]=1 and no ack has been received.
  - May present the next byte the cycle after ack by keeping req high with new data.
- req[i] dropped after grant: the latched byte is still sent and ack still pulses; the requester ignores it.
- req[i] dropped before grant: no effect.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0; no requester waits more than N-1 transfers.
- ack and grant are never asserted for a non-winning index. At most one ack bit is high in any cycle.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- Defined: lock[N-1:0] port exists (multi-byte messages).
  - In IDLE, if the previous winner w has lock[w]=1 and req[w]=1, w is re-granted regardless of round-robin.
  - Lock is ignored after a timeout.
- Undefined: no lock port; pure round-robin every byte.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'h55 ("U") -> uart_send pulse 1 cycle later, uart_data=8'h55, ack[0] 1 cycle after busy rises, grant=0 after busy falls.
- All four request continuously -> grant/ack order 0,1,2,3,0; each uart_send occurs only after busy has been low for at least 1 cycle.
- Model uart_busy stuck at 0 -> timeout pulses 15 cycles after WAIT_BUSY entry, no ack, grant=0; next grant goes to a different requester if one is pending.
- rst asserted during WAIT_DONE with busy=1 -> all outputs 0 immediately; after release, requester 0 wins first.
- With UART_TX_ARB_LOCK_EN, req=4'b0011 and lock[1]=1 while requester 1 holds the grant -> three consecutive bytes from requester 1; requester 0 is served after lock[1] drops.
